// File: rtl/slow_clk_monitor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : slow_clk_monitor_if
//  Brief    : Signal bundle between a slow square-wave source and the
//             slow_clk_monitor block that checks it.
//  Revision : 1.0 - initial release
// ============================================================================
interface slow_clk_monitor_if #(
  parameter int CNT_W = 28
) ();
  logic             clk_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             lost;

  // Source side: produces the slow wave, observes the monitor results
  modport master (
    output clk_in,
    input  rise_pulse, fall_pulse, period, period_valid, locked, lost
  );

  // Monitor side: consumes the slow wave, produces ticks and status
  modport slave (
    input  clk_in,
    output rise_pulse, fall_pulse, period, period_valid, locked, lost
  );
endinterface
`default_nettype wire

// File: rtl/slow_clk_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : slow_clk_monitor
//  Brief    : Synchronizes a slow square wave, emits one-cycle rise/fall
//             ticks, measures the rising-to-rising period and reports
//             lock against an expected period or loss after a timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module slow_clk_monitor #(
  parameter int unsigned EXP_PERIOD = 100000000,
  parameter int unsigned TOLERANCE  = 1000,
  parameter int unsigned TIMEOUT    = 150000000,
  parameter int          CNT_W      = 28
) (
  input  wire logic          clk,
  input  wire logic          rst,
  slow_clk_monitor_if.slave  mon_if
);

  // Lock window and timeout, fixed at elaboration
  localparam logic [CNT_W-1:0] LO_BOUND  = CNT_W'(EXP_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0] HI_BOUND  = CNT_W'(EXP_PERIOD + TOLERANCE);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pvalid_q, pvalid_d;
  logic             locked_q;
  logic             lost_q, lost_d;

  logic             rise, fall, in_range;
  logic [CNT_W-1:0] cnt_inc;

  // Edge detect on the synchronized wave; s3 is the one-cycle history
  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  // cnt holds (cycles since last rise) - 1, so +1 is the interval length
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign in_range = (cnt_inc >= LO_BOUND) && (cnt_inc <= HI_BOUND);

  // Two-flop synchronizer, history flop and registered edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= mon_if.clk_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise;
      fall_q <= fall;
    end
  end

  // State, interval counter and status output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      locked_q <= (state_d == S_LOCKED);
      lost_q   <= lost_d;
    end
  end

  // Next state: a rise always wins over a coincident timeout
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    pvalid_d = 1'b0;
    lost_d   = lost_q;
    cnt_d    = (cnt_q == TMO_LIMIT) ? cnt_q : cnt_inc;

    if (rise) begin
      cnt_d  = '0;
      lost_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          // First edge only establishes the reference point
          state_d = S_MEASURE;
        end
        S_MEASURE, S_LOCKED: begin
          pvalid_d = 1'b1;
          period_d = cnt_inc;
          state_d  = in_range ? S_LOCKED : S_MEASURE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && (cnt_inc == TMO_LIMIT)) begin
      state_d = S_IDLE;
      lost_d  = 1'b1;
    end
  end

  assign mon_if.rise_pulse   = rise_q;
  assign mon_if.fall_pulse   = fall_q;
  assign mon_if.period       = period_q;
  assign mon_if.period_valid = pvalid_q;
  assign mon_if.locked       = locked_q;
  assign mon_if.lost         = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_clk_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_slow_clk_monitor
//  Brief    : Scoreboard bench for slow_clk_monitor. The driver predicts
//             every edge pulse when it drives the wave; the monitor pops
//             predictions and tracks the expected lock/loss levels.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slow_clk_monitor;

  localparam int EXP = 20;
  localparam int TOL = 2;
  localparam int TMO = 40;
  localparam int CW  = 8;

  typedef struct packed {
    logic        is_rise;
    logic [31:0] cyc;
    logic        valid;
    logic [31:0] period;
    logic        locked;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t q[$];
  int   last_rise = 0;
  bit   have_ref  = 1'b0;

  // Monitor-side expected levels
  logic          m_locked = 1'b0;
  logic          m_lost   = 1'b0;
  logic [CW-1:0] m_period = '0;
  bit            m_armed  = 1'b0;
  int            m_last_rp = 0;
  bit            m_chg;
  logic          exp_valid;
  exp_t          pe;

  slow_clk_monitor_if #(.CNT_W(CW)) mif ();

  slow_clk_monitor #(
    .EXP_PERIOD(EXP),
    .TOLERANCE (TOL),
    .TIMEOUT   (TMO),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .mon_if(mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Hold clk_in at v for n cycles; predict the pulse on a level change
  task automatic hold(input logic v, input int n);
    exp_t e;
    int   iv;
    @(negedge clk);
    if (v !== mif.clk_in) begin
      e.is_rise = v;
      e.cyc     = 32'(cyc + 3);
      e.valid   = 1'b0;
      e.period  = '0;
      e.locked  = 1'b0;
      if (v) begin
        iv       = cyc - last_rise;
        e.valid  = have_ref && (iv <= TMO);
        e.period = 32'(iv);
        e.locked = e.valid && (iv >= EXP - TOL) && (iv <= EXP + TOL);
        have_ref  = 1'b1;
        last_rise = cyc;
      end
      q.push_back(e);
    end
    mif.clk_in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wave(input int h, input int l, input int k);
    repeat (k) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_rise"},   32'(mif.rise_pulse),   32'd0);
    check_eq({pfx, "_fall"},   32'(mif.fall_pulse),   32'd0);
    check_eq({pfx, "_period"}, 32'(mif.period),       32'd0);
    check_eq({pfx, "_pvalid"}, 32'(mif.period_valid), 32'd0);
    check_eq({pfx, "_locked"}, 32'(mif.locked),       32'd0);
    check_eq({pfx, "_lost"},   32'(mif.lost),         32'd0);
  endtask

  // Pop predictions at their due cycle and compare status levels
  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_locked = 1'b0;
      m_lost   = 1'b0;
      m_period = '0;
      m_armed  = 1'b0;
    end else begin
      m_chg     = 1'b0;
      exp_valid = 1'b0;
      if (q.size() > 0 && q[0].cyc == 32'(cyc)) begin
        pe = q.pop_front();
        if (pe.is_rise) begin
          check_eq("rise_pulse", 32'({mif.rise_pulse, mif.fall_pulse}), 32'd2);
          exp_valid = pe.valid;
          m_lost    = 1'b0;
          m_armed   = 1'b1;
          m_last_rp = cyc;
          m_locked  = pe.locked;
          if (pe.valid) m_period = pe.period[CW-1:0];
          m_chg = 1'b1;
        end else begin
          check_eq("fall_pulse", 32'({mif.rise_pulse, mif.fall_pulse}), 32'd1);
        end
      end else begin
        if (mif.rise_pulse || mif.fall_pulse)
          check_eq("stray_pulse", 32'({mif.rise_pulse, mif.fall_pulse}), 32'd0);
        if (m_armed && cyc == m_last_rp + TMO) begin
          m_lost   = 1'b1;
          m_locked = 1'b0;
          m_armed  = 1'b0;
          m_chg    = 1'b1;
        end
      end
      if (exp_valid || mif.period_valid)
        check_eq("period_valid", 32'(mif.period_valid), 32'(exp_valid));
      if (m_chg || mif.period !== m_period)
        check_eq("period", 32'(mif.period), 32'(m_period));
      if (m_chg || mif.locked !== m_locked)
        check_eq("locked", 32'(mif.locked), 32'(m_locked));
      if (m_chg || mif.lost !== m_lost)
        check_eq("lost", 32'(mif.lost), 32'(m_lost));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    mif.clk_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    wave(10, 10, 4);           // reference edge, then locked at 20
    wave(12, 11, 3);           // period 23 drops lock
    wave(10, 10, 3);           // relock
    wave(9, 9, 1);             // 18: lower bound
    wave(11, 11, 1);           // 22: upper bound
    wave(9, 8, 1);             // 17: out of range
    wave(10, 10, 2);

    hold(1'b1, 10);            // rise, then starve the input
    hold(1'b0, 60);
    wave(10, 10, 3);           // recovery edge, then normal measurement

    hold(1'b1, 6);             // pulses 6 cycles apart
    hold(1'b0, 30);
    wave(10, 10, 2);

    // Asynchronous reset in the middle of a low phase while locked
    hold(1'b1, 10);
    hold(1'b0, 5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    have_ref = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wave(10, 10, 3);

    repeat (10) @(negedge clk);
    check_eq("sb_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
